// File: rtl/ram_scan_master.sv
// Sole master of the single-port data RAM. Scans a wrap-around window of signed words
// for sum/min/max and can write the three results back after the scan completes.
module ram_scan_master #(
    parameter int AW = 9,
    parameter int DW = 32
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     start,
    input  logic [AW-1:0]            base_addr,
    input  logic [AW:0]              count,
    input  logic                     wb_en,
    input  logic [AW-1:0]            wb_addr,
    output logic                     busy,
    output logic                     done,
    output logic signed [DW+AW-1:0]  sum,
    output logic signed [DW-1:0]     min_val,
    output logic signed [DW-1:0]     max_val,
    output logic [AW-1:0]            mem_addr,
    output logic                     mem_rw,
    output logic [DW-1:0]            mem_wdata,
    input  logic [DW-1:0]            mem_rdata
);
    typedef enum logic [2:0] {IDLE, READ, WB_MIN, WB_MAX, WB_SUM, DONE} state_t;

    localparam logic [AW:0]          DEPTH   = {1'b1, {AW{1'b0}}};
    localparam logic [AW:0]          CNT_ONE = (AW+1)'(1);
    localparam logic signed [DW-1:0] MOST_POS = {1'b0, {(DW-1){1'b1}}};
    localparam logic signed [DW-1:0] MOST_NEG = {1'b1, {(DW-1){1'b0}}};

    function automatic logic signed [DW+AW-1:0] sext(input logic [DW-1:0] w);
        return {{AW{w[DW-1]}}, w};
    endfunction

    function automatic logic signed [DW-1:0] smin(input logic signed [DW-1:0] a,
                                                  input logic signed [DW-1:0] b);
        return (b < a) ? b : a;
    endfunction

    function automatic logic signed [DW-1:0] smax(input logic signed [DW-1:0] a,
                                                  input logic signed [DW-1:0] b);
        return (b > a) ? b : a;
    endfunction

    state_t                   state_q, state_d;
    logic [AW-1:0]            addr_q, addr_d;
    logic                     rw_q, rw_d;
    logic [DW-1:0]            wdata_q, wdata_d;
    logic [AW:0]              cnt_q, cnt_d;
    logic                     wb_en_q, wb_en_d;
    logic [AW-1:0]            wb_addr_q, wb_addr_d;
    logic signed [DW+AW-1:0]  acc_sum_q, acc_sum_d;
    logic signed [DW-1:0]     acc_min_q, acc_min_d;
    logic signed [DW-1:0]     acc_max_q, acc_max_d;
    logic signed [DW+AW-1:0]  sum_q, sum_d;
    logic signed [DW-1:0]     min_q, min_d;
    logic signed [DW-1:0]     max_q, max_d;
    logic signed [DW+AW-1:0]  rd_sum;
    logic signed [DW-1:0]     rd_min, rd_max;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= IDLE;
            addr_q    <= '0;
            rw_q      <= 1'b1;
            wdata_q   <= '0;
            cnt_q     <= '0;
            wb_en_q   <= 1'b0;
            wb_addr_q <= '0;
            acc_sum_q <= '0;
            acc_min_q <= '0;
            acc_max_q <= '0;
            sum_q     <= '0;
            min_q     <= '0;
            max_q     <= '0;
        end else begin
            state_q   <= state_d;
            addr_q    <= addr_d;
            rw_q      <= rw_d;
            wdata_q   <= wdata_d;
            cnt_q     <= cnt_d;
            wb_en_q   <= wb_en_d;
            wb_addr_q <= wb_addr_d;
            acc_sum_q <= acc_sum_d;
            acc_min_q <= acc_min_d;
            acc_max_q <= acc_max_d;
            sum_q     <= sum_d;
            min_q     <= min_d;
            max_q     <= max_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        addr_d    = addr_q;
        rw_d      = 1'b1;
        wdata_d   = wdata_q;
        cnt_d     = cnt_q;
        wb_en_d   = wb_en_q;
        wb_addr_d = wb_addr_q;
        acc_sum_d = acc_sum_q;
        acc_min_d = acc_min_q;
        acc_max_d = acc_max_q;
        sum_d     = sum_q;
        min_d     = min_q;
        max_d     = max_q;
        rd_sum    = acc_sum_q + sext(mem_rdata);
        rd_min    = smin(acc_min_q, mem_rdata);
        rd_max    = smax(acc_max_q, mem_rdata);

        case (state_q)
            IDLE: begin
                if (start) begin
                    cnt_d     = (count > DEPTH) ? DEPTH : count;
                    wb_en_d   = wb_en;
                    wb_addr_d = wb_addr;
                    acc_sum_d = '0;
                    acc_min_d = MOST_POS;
                    acc_max_d = MOST_NEG;
                    addr_d    = base_addr;
                    state_d   = READ;
                end
            end
            READ: begin
                // An empty window still spends one cycle here so done lands max(count,1) edges out
                if (cnt_q == '0) begin
                    sum_d = '0;
                    min_d = '0;
                    max_d = '0;
                    if (wb_en_q) begin
                        state_d = WB_MIN;
                        rw_d    = 1'b0;
                        addr_d  = wb_addr_q;
                        wdata_d = '0;
                    end else begin
                        state_d = DONE;
                    end
                end else begin
                    acc_sum_d = rd_sum;
                    acc_min_d = rd_min;
                    acc_max_d = rd_max;
                    addr_d    = addr_q + AW'(1);
                    cnt_d     = cnt_q - CNT_ONE;
                    if (cnt_q == CNT_ONE) begin
                        sum_d = rd_sum;
                        min_d = rd_min;
                        max_d = rd_max;
                        if (wb_en_q) begin
                            state_d = WB_MIN;
                            rw_d    = 1'b0;
                            addr_d  = wb_addr_q;
                            wdata_d = rd_min;
                        end else begin
                            state_d = DONE;
                        end
                    end
                end
            end
            WB_MIN: begin
                state_d = WB_MAX;
                rw_d    = 1'b0;
                addr_d  = wb_addr_q + AW'(1);
                wdata_d = max_q;
            end
            WB_MAX: begin
                state_d = WB_SUM;
                rw_d    = 1'b0;
                addr_d  = wb_addr_q + AW'(2);
                wdata_d = sum_q[DW-1:0];
            end
            WB_SUM:  state_d = DONE;
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    assign busy      = (state_q != IDLE);
    assign done      = (state_q == DONE);
    assign sum       = sum_q;
    assign min_val   = min_q;
    assign max_val   = max_q;
    assign mem_addr  = addr_q;
    assign mem_rw    = rw_q;
    assign mem_wdata = wdata_q;
endmodule

// File: tb/tb_ram_scan_master.sv
// Bench for ram_scan_master: behavioural RAM plus a window sum/min/max reference model,
// directed corner cases followed by randomized scans.
module tb_ram_scan_master;
    localparam int AW = 9;
    localparam int DW = 32;
    localparam int DEPTH = 1 << AW;

    logic              clk = 1'b0;
    logic              rst = 1'b1;
    logic              start = 1'b0;
    logic [AW-1:0]     base_addr = '0;
    logic [AW:0]       count = '0;
    logic              wb_en = 1'b0;
    logic [AW-1:0]     wb_addr = '0;
    logic              busy, done;
    logic [DW+AW-1:0]  sum;
    logic [DW-1:0]     min_val, max_val;
    logic [AW-1:0]     mem_addr;
    logic              mem_rw;
    logic [DW-1:0]     mem_wdata, mem_rdata;

    logic [DW-1:0]     ram [DEPTH];
    logic [DW-1:0]     ref_mem [DEPTH];
    logic              load_req = 1'b0;
    int                n_assert = 0;
    int                n_fail = 0;
    int                wr_cnt = 0;
    int                done_cnt = 0;
    logic [AW-1:0]     rd_q [$];

    ram_scan_master #(.AW(AW), .DW(DW)) dut (
        .clk(clk), .rst(rst), .start(start), .base_addr(base_addr), .count(count),
        .wb_en(wb_en), .wb_addr(wb_addr), .busy(busy), .done(done), .sum(sum),
        .min_val(min_val), .max_val(max_val), .mem_addr(mem_addr), .mem_rw(mem_rw),
        .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
    );

    always #5 clk = ~clk;

    assign mem_rdata = ram[mem_addr];

    always @(posedge clk) begin
        if (load_req) begin
            for (int i = 0; i < DEPTH; i++) ram[i] <= ref_mem[i];
        end else if (!mem_rw) begin
            ram[mem_addr] <= mem_wdata;
        end
    end

    always @(negedge clk) begin
        if (!mem_rw) wr_cnt++;
        if (done) done_cnt++;
        if (busy && mem_rw && !done) rd_q.push_back(mem_addr);
    end

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic load_ram();
        @(negedge clk);
        load_req = 1'b1;
        @(negedge clk);
        load_req = 1'b0;
    endtask

    task automatic compare_ram(input string tag);
        int bad;
        bad = 0;
        for (int i = 0; i < DEPTH; i++) if (ram[i] !== ref_mem[i]) bad++;
        chk({tag, " ram_contents"}, 64'(bad), 64'd0);
    endtask

    task automatic run_op(input string tag, input int base, input int cnt, input bit wbe,
                          input int wba, input bit poke);
        int n, v, w0, d0, r0, lat, bad, exp_lat, mn, mx;
        longint s;
        logic [DW+AW-1:0] e_sum;
        logic [DW-1:0] e_min, e_max;
        n = (cnt > DEPTH) ? DEPTH : cnt;
        s = 0; mn = 0; mx = 0;
        for (int i = 0; i < n; i++) begin
            v = $signed(ref_mem[(base + i) % DEPTH]);
            s += v;
            if (i == 0 || v < mn) mn = v;
            if (i == 0 || v > mx) mx = v;
        end
        e_sum = s[DW+AW-1:0];
        e_min = mn;
        e_max = mx;
        exp_lat = ((n == 0) ? 1 : n) + (wbe ? 3 : 0);
        w0 = wr_cnt; d0 = done_cnt; r0 = rd_q.size();

        @(negedge clk);
        start = 1'b1; base_addr = base[AW-1:0]; count = cnt[AW:0];
        wb_en = wbe; wb_addr = wba[AW-1:0];
        @(posedge clk); #1;
        start = 1'b0;
        lat = 0;
        for (int k = 1; k <= DEPTH + 8; k++) begin
            @(posedge clk); #1;
            start = 1'b0;
            if (done) begin lat = k; break; end
            if (poke && k == 1) begin start = 1'b1; base_addr = ~base_addr; count = 3; end
        end
        chk({tag, " latency"}, 64'(lat), 64'(exp_lat));
        chk({tag, " busy_at_done"}, 64'(busy), 64'd1);
        chk({tag, " sum"}, 64'(sum), 64'(e_sum));
        chk({tag, " min"}, 64'(min_val), 64'(e_min));
        chk({tag, " max"}, 64'(max_val), 64'(e_max));
        if (poke) start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        chk({tag, " done_pulse_ends"}, 64'(done), 64'd0);
        chk({tag, " idle_after_done"}, 64'(busy), 64'd0);
        if (poke) begin
            repeat (4) @(posedge clk);
            #1;
            chk({tag, " no_restart"}, 64'(busy), 64'd0);
        end
        chk({tag, " done_count"}, 64'(done_cnt - d0), 64'd1);
        chk({tag, " write_cycles"}, 64'(wr_cnt - w0), wbe ? 64'd3 : 64'd0);
        if (n > 0) begin
            chk({tag, " read_count"}, 64'(rd_q.size() - r0), 64'(n));
            bad = 0;
            if (rd_q.size() - r0 == n)
                for (int i = 0; i < n; i++)
                    if (rd_q[r0 + i] !== AW'((base + i) % DEPTH)) bad++;
            chk({tag, " read_order"}, 64'(bad), 64'd0);
        end
        if (wbe) begin
            ref_mem[wba % DEPTH]       = e_min;
            ref_mem[(wba + 1) % DEPTH] = e_max;
            ref_mem[(wba + 2) % DEPTH] = e_sum[DW-1:0];
        end
        compare_ram(tag);
    endtask

    initial begin
        int w0;
        for (int i = 0; i < DEPTH; i++) ref_mem[i] = $urandom;
        repeat (3) @(posedge clk);
        #1;
        chk("reset busy", 64'(busy), 64'd0);
        chk("reset done", 64'(done), 64'd0);
        chk("reset sum", 64'(sum), 64'd0);
        chk("reset min", 64'(min_val), 64'd0);
        chk("reset max", 64'(max_val), 64'd0);
        chk("reset mem_addr", 64'(mem_addr), 64'd0);
        chk("reset mem_rw", 64'(mem_rw), 64'd1);
        chk("reset mem_wdata", 64'(mem_wdata), 64'd0);
        @(negedge clk);
        rst = 1'b0;

        ref_mem[0] = 5; ref_mem[1] = -3; ref_mem[2] = 10; ref_mem[3] = -7;
        load_ram();
        run_op("basic", 0, 4, 1'b0, 0, 1'b0);

        ref_mem[510] = 100; ref_mem[511] = -200; ref_mem[0] = 50;
        load_ram();
        run_op("wrap", 510, 3, 1'b0, 0, 1'b0);
        ref_mem[511] = -200; ref_mem[0] = 50;
        load_ram();
        run_op("wrap_wb", 510, 3, 1'b1, 511, 1'b0);
        chk("wrap_wb sum_word", 64'(ram[1]), 64'hFFFFFFCE);

        for (int i = 0; i < DEPTH; i++) ref_mem[i] = 32'h7FFFFFFF;
        load_ram();
        run_op("clamp", 17, 600, 1'b0, 0, 1'b0);
        chk("clamp sum_value", 64'(sum), 64'h0FFFFFFFE00);

        run_op("empty", 5, 0, 1'b0, 0, 1'b1);
        run_op("empty_wb", 5, 0, 1'b1, 300, 1'b0);
        run_op("busy_start", 40, 6, 1'b0, 0, 1'b1);

        ref_mem[0] = 7; ref_mem[1] = -9; ref_mem[102] = 32'h12345678;
        load_ram();
        w0 = wr_cnt;
        @(negedge clk);
        start = 1'b1; base_addr = 0; count = 2; wb_en = 1'b1; wb_addr = 100;
        @(posedge clk); #1;
        start = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_mid in_wb_max rw", 64'(mem_rw), 64'd0);
        chk("rst_mid in_wb_max addr", 64'(mem_addr), 64'd101);
        rst = 1'b1;
        @(posedge clk); #1;
        chk("rst_mid mem_rw", 64'(mem_rw), 64'd1);
        chk("rst_mid busy", 64'(busy), 64'd0);
        chk("rst_mid done", 64'(done), 64'd0);
        chk("rst_mid sum", 64'(sum), 64'd0);
        chk("rst_mid min", 64'(min_val), 64'd0);
        chk("rst_mid max", 64'(max_val), 64'd0);
        rst = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_mid write_cycles", 64'(wr_cnt - w0), 64'd2);
        chk("rst_mid sum_slot_kept", 64'(ram[102]), 64'h12345678);
        ref_mem[100] = -9; ref_mem[101] = 7;
        compare_ram("rst_mid");
        run_op("after_rst", 0, 2, 1'b1, 100, 1'b0);

        for (int t = 0; t < 8; t++) begin
            for (int i = 0; i < DEPTH; i++) ref_mem[i] = $urandom;
            load_ram();
            run_op($sformatf("rand%0d", t), int'($urandom_range(0, DEPTH - 1)),
                   (t == 7) ? int'($urandom_range(513, 1023)) : int'($urandom_range(0, 40)),
                   1'($urandom_range(0, 1)), int'($urandom_range(0, DEPTH - 1)), t == 3);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end
endmodule
